// File: rtl/uart_rx_byte.sv
// -----------------------------------------------------------------------------
// uart_rx_byte
//
// 8N1 UART receiver for the serial monitor link. The asynchronous uart_rx pin
// is brought into the clk_27mhz domain through a two-flop synchroniser. A small
// FSM finds the start bit, confirms it half a bit later, samples eight data
// bits (LSB first) and the stop bit at mid-bit. It then hands the byte to a
// single-entry valid/ready output register.
//
// Ports
//   clk_27mhz  in   system clock
//   rst        in   synchronous, active-high reset
//   uart_rx    in   asynchronous serial line, idle high
//   rx_data    out  received byte, meaningful while rx_valid=1
//   rx_valid   out  rx_data holds a byte not yet accepted
//   rx_ready   in   consumer takes rx_data on a clock edge with rx_valid=1
//   rx_busy    out  FSM is anywhere other than IDLE
//   frame_err  out  one-cycle pulse: stop bit sampled low, byte discarded
//   overrun    out  one-cycle pulse: good byte dropped, output register full
// -----------------------------------------------------------------------------
module uart_rx_byte #(
  parameter int unsigned CLKS_PER_BIT = 234  // clk_27mhz cycles per bit, >= 4
) (
  input  logic       clk_27mhz,
  input  logic       rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  // ---------------------------------------------------------------------------
  // Synchroniser. Both stages reset high so that reset never looks like a
  // start bit.
  // ---------------------------------------------------------------------------
  logic sync_meta_q;
  logic rx_s_q;

  // NOTE: clocked state always uses non-blocking assignments so every flop
  // samples the pre-edge value of the others; blocking here would collapse
  // the two synchroniser stages into one.
  always_ff @(posedge clk_27mhz) begin
    if (rst) begin
      sync_meta_q <= 1'b1;
      rx_s_q      <= 1'b1;
    end else begin
      sync_meta_q <= uart_rx;
      rx_s_q      <= sync_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       data_q;
  logic             valid_q;
  logic             busy_q;
  logic             frame_err_q;
  logic             overrun_q;

  // LSB arrives first: shift right and bring the new bit in at the MSB, so
  // after eight samples bit 0 of the byte sits in shift_q[0].
  assign shift_d = {rx_s_q, shift_q[7:1]};

  always_ff @(posedge clk_27mhz) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      // Error flags are single-cycle pulses unless re-asserted below.
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer handshake. A delivery in S_STOP below overrides this in
      // the same cycle, giving accept-and-refill with no bubble.
      if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end

      unique case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_q <= S_START;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt_q == CNT_HALF_LAST) begin
            cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end else begin
              // Line went high again before mid-start-bit: treat it as a glitch.
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_DATA: begin
          if (cnt_q == CNT_BIT_LAST) begin
            shift_q   <= shift_d;
            cnt_q     <= '0;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_STOP;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_STOP: begin
          if (cnt_q == CNT_BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              if (!valid_q || rx_ready) begin
                data_q  <= shift_q;
                valid_q <= 1'b1;
              end else begin
                overrun_q <= 1'b1;
              end
            end else begin
              // Bad stop bit: drop the byte and wait for the line to go
              // high, so a break is not decoded as a run of 0x00 frames.
              frame_err_q <= 1'b1;
              state_q     <= S_WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        S_WAIT_IDLE: begin
          if (rx_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign rx_busy   = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_byte
//
// Self-checking bench for uart_rx_byte. Serial frames are driven on falling
// clock edges. Each frame that should be delivered pushes its byte and its
// expected load cycle (E0 + 2 + HALF_BIT + 9*CLKS_PER_BIT) into a scoreboard
// queue. A monitor samples 1 ns after every rising edge, pops the queue on
// every byte load, and counts error pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx_byte;

  localparam int CPB      = 234;
  localparam int HALF     = CPB / 2;
  localparam int STOP_LAT = 2 + HALF + 9 * CPB;  // 2225 for CPB=234

  logic       clk_27mhz = 1'b0;
  logic       rst       = 1'b1;
  logic       uart_rx   = 1'b1;
  logic       rx_ready  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  always #5 clk_27mhz = ~clk_27mhz;

  uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
    .clk_27mhz (clk_27mhz),
    .rst       (rst),
    .uart_rx   (uart_rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_busy   (rx_busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_fe;
    int         exp_loads;
  } vec_t;

  exp_t sb_q[$];

  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   load_count  = 0;
  int   fe_count    = 0;
  int   ov_count    = 0;
  int   fe_cyc      = 0;
  int   ov_cyc      = 0;
  int   busy_cycles = 0;
  logic prev_valid  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor. At posedge+1 the inputs still hold the values used at that edge.
  always @(posedge clk_27mhz) begin
    exp_t e;
    cyc++;
    #1;
    if (!rst) begin
      if (rx_valid && (!prev_valid || rx_ready)) begin
        load_count++;
        if (sb_q.size() == 0) begin
          check("unexpected_load_queue_depth", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check("rx_data", 32'(rx_data), 32'(e.data));
          check("load_cycle", 32'(cyc), 32'(e.due));
        end
      end
      if (frame_err) begin
        fe_count++;
        fe_cyc = cyc;
      end
      if (overrun) begin
        ov_count++;
        ov_cyc = cyc;
      end
      if (frame_err || overrun) begin
        check("err_mutex", 32'(frame_err & overrun), 32'd0);
      end
      if (rx_busy) busy_cycles++;
    end
    prev_valid = rx_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_27mhz);
  endtask

  // Called on a falling edge; returns on a falling edge with the line left at
  // the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic expect_load, output int e0);
    uart_rx = 1'b0;
    e0      = cyc + 1;
    if (expect_load) sb_q.push_back('{data: d, due: e0 + STOP_LAT});
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rx_data"},   32'(rx_data),   32'd0);
    check({tag, "_rx_valid"},  32'(rx_valid),  32'd0);
    check({tag, "_rx_busy"},   32'(rx_busy),   32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    int   e0;
    int   e0b;
    int   l0;
    int   fe0;
    int   ov0;

    vecs[0] = '{data: 8'h00, stop: 1'b1, exp_fe: 0, exp_loads: 1};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_fe: 0, exp_loads: 1};
    vecs[2] = '{data: 8'h3A, stop: 1'b0, exp_fe: 1, exp_loads: 0};
    vecs[3] = '{data: 8'hC6, stop: 1'b1, exp_fe: 0, exp_loads: 1};

    // Reset
    rst = 1'b1; uart_rx = 1'b1; rx_ready = 1'b1;
    idle(4);
    check_reset_values("reset");
    rst = 1'b0;
    idle(10);

    // Single 0x55 with exact load timing
    send_frame(8'h55, 1'b1, 1'b1, e0);
    uart_rx = 1'b1;
    idle(20);
    check("q_empty_55", 32'(sb_q.size()), 32'd0);
    check("no_fe_55", 32'(fe_count), 32'd0);
    check("no_ov_55", 32'(ov_count), 32'd0);

    // Back-to-back 0xA5, 0x3C with no idle gap
    l0 = load_count;
    send_frame(8'hA5, 1'b1, 1'b1, e0);
    send_frame(8'h3C, 1'b1, 1'b1, e0b);
    uart_rx = 1'b1;
    idle(20);
    check("b2b_loads", 32'(load_count - l0), 32'd2);
    check("b2b_spacing", 32'(e0b - e0), 32'(10 * CPB));

    // Table-driven frames, consumer always ready
    for (int i = 0; i < 4; i++) begin
      fe0 = fe_count;
      l0  = load_count;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].stop, e0);
      uart_rx = 1'b1;
      idle(30);
      check($sformatf("vec%0d_fe", i), 32'(fe_count - fe0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d_loads", i), 32'(load_count - l0), 32'(vecs[i].exp_loads));
      if (vecs[i].exp_fe != 0) check($sformatf("vec%0d_fe_cycle", i), 32'(fe_cyc), 32'(e0 + STOP_LAT));
    end

    // Start-bit glitch: 50 cycles low, rejected at the half-bit check
    busy_cycles = 0;
    l0  = load_count;
    fe0 = fe_count;
    uart_rx = 1'b0;
    idle(50);
    uart_rx = 1'b1;
    idle(250);
    check("glitch_busy_cycles", 32'(busy_cycles), 32'(HALF));
    check("glitch_no_load", 32'(load_count - l0), 32'd0);
    check("glitch_no_fe", 32'(fe_count - fe0), 32'd0);

    // 0x81 with low stop bit, then the line held low (break)
    fe0 = fe_count;
    l0  = load_count;
    send_frame(8'h81, 1'b0, 1'b0, e0);
    idle(5000);
    check("break_busy_wait_idle", 32'(rx_busy), 32'd1);
    check("break_fe_once", 32'(fe_count - fe0), 32'd1);
    check("break_fe_cycle", 32'(fe_cyc), 32'(e0 + STOP_LAT));
    check("break_no_load", 32'(load_count - l0), 32'd0);
    uart_rx = 1'b1;
    idle(10);
    check("break_released_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h42, 1'b1, 1'b1, e0);
    uart_rx = 1'b1;
    idle(20);
    check("after_break_loads", 32'(load_count - l0), 32'd1);

    // Overrun: consumer not ready, two frames
    rx_ready = 1'b0;
    ov0 = ov_count;
    fe0 = fe_count;
    send_frame(8'h11, 1'b1, 1'b1, e0);
    uart_rx = 1'b1;
    idle(20);
    send_frame(8'h22, 1'b1, 1'b0, e0b);
    uart_rx = 1'b1;
    idle(20);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'h11);
    check("ovr_pulse_count", 32'(ov_count - ov0), 32'd1);
    check("ovr_pulse_cycle", 32'(ov_cyc), 32'(e0b + STOP_LAT));
    check("ovr_no_fe", 32'(fe_count - fe0), 32'd0);
    rx_ready = 1'b1;
    idle(1);
    rx_ready = 1'b0;
    idle(2);
    check("ovr_accept_valid", 32'(rx_valid), 32'd0);
    check("ovr_data_not_22", 32'(rx_data != 8'h22), 32'd1);

    // Reset in the middle of DATA with a byte pending
    send_frame(8'h77, 1'b1, 1'b1, e0);
    uart_rx = 1'b1;
    idle(20);
    check("pending_before_reset", 32'(rx_valid), 32'd1);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 3; i++) begin
      uart_rx = 1'(8'hF0 >> i);
      idle(CPB);
    end
    check("busy_mid_frame", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    uart_rx = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    check_reset_values("midreset");
    rx_ready = 1'b1;
    l0 = load_count;
    send_frame(8'h0F, 1'b1, 1'b1, e0);
    uart_rx = 1'b1;
    idle(20);
    check("after_reset_load", 32'(load_count - l0), 32'd1);

    check("final_queue_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
